// File: rtl/program_dump_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_dump_tx_pkg
// Description : Shared constants and state types for the program dump path.
// Revision    : 1.0 - initial release
// ============================================================================
package program_dump_tx_pkg;

    localparam int   c_DATA_BITS  = 8;
    localparam logic c_UART_IDLE  = 1'b1;
    localparam logic c_UART_START = 1'b0;
    localparam logic c_UART_STOP  = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } dump_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_SEND = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/program_dump_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : program_dump_tx_if
// Description : Dump request, program-memory read port and UART status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface program_dump_tx_if #(
    parameter int ADDR_W = 4,
    parameter int WORD_W = 7
);
    logic              dump_start_i;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [WORD_W-1:0] mem_data_i;
    logic              tx_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        input  dump_start_i, mem_data_i,
        output mem_addr_o, tx_o, busy_o, done_o
    );

    modport slave (
        output dump_start_i, mem_data_i,
        input  mem_addr_o, tx_o, busy_o, done_o
    );
endinterface
`default_nettype wire

// File: rtl/program_dump_tx_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : program_dump_tx_uart_tx_serializer
// Description : 8N1 UART byte transmitter with valid/ready byte intake.
// Revision    : 1.0 - initial release
// ============================================================================
module program_dump_tx_uart_tx_serializer
    import program_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1042
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [c_DATA_BITS-1:0] i_byte,
    input  wire logic                   i_valid,
    output logic                        o_ready,
    output logic                        o_last,
    output logic                        o_tx
);
    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IDX_W  = $clog2(c_DATA_BITS);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(c_DATA_BITS - 1);

    dump_state_t            r_state,   w_state_nxt;
    logic [c_BAUD_W-1:0]    r_baud,    w_baud_nxt;
    logic [c_IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
    logic [c_DATA_BITS-1:0] r_shift,   w_shift_nxt;
    logic                   r_tx,      w_tx_nxt;
    logic                   w_baud_last;

    assign w_baud_last = (r_baud == c_BAUD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_baud_nxt    = w_baud_last ? '0 : r_baud + 1'b1;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        case (r_state)
            IDLE: begin
                w_baud_nxt = '0;
                if (i_valid) begin
                    w_shift_nxt = i_byte;
                    w_state_nxt = START;
                end
            end
            START: if (w_baud_last) begin
                w_state_nxt   = DATA;
                w_bit_idx_nxt = '0;
            end
            DATA: if (w_baud_last) begin
                if (r_bit_idx == c_IDX_LAST) w_state_nxt = STOP;
                else                         w_bit_idx_nxt = r_bit_idx + 1'b1;
            end
            STOP: if (w_baud_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Line level is decoded from the next state so o_tx stays a flop output.
        case (w_state_nxt)
            START:   w_tx_nxt = c_UART_START;
            DATA:    w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
            STOP:    w_tx_nxt = c_UART_STOP;
            default: w_tx_nxt = c_UART_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= c_UART_IDLE;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    assign o_ready = (r_state == IDLE);
    assign o_last  = (r_state == STOP) && w_baud_last;
    assign o_tx    = r_tx;

endmodule
`default_nettype wire

// File: rtl/program_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : program_dump_tx
// Description : Walks program memory from address 0 and sends each word as UART.
// Revision    : 1.0 - initial release
// ============================================================================
module program_dump_tx
    import program_dump_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT         = 1042,
    parameter int OPERATION_CODE_WIDTH = 3,
    parameter int REGISTER_WIDTH       = 4,
    parameter int MEMORY_ADDRESS_WIDTH = 4,
    parameter int MEMORY_REGISTERS     = 16
) (
    input  wire logic          clk_i,
    input  wire logic          reset_i,
    program_dump_tx_if.master  bus
);
    localparam int c_WORD_W = OPERATION_CODE_WIDTH + REGISTER_WIDTH;
    localparam logic [MEMORY_ADDRESS_WIDTH-1:0] c_ADDR_LAST =
        MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);

    seq_state_t                      r_state, w_state_nxt;
    logic [MEMORY_ADDRESS_WIDTH-1:0] r_addr,  w_addr_nxt;
    logic                            r_busy,  w_busy_nxt;
    logic                            r_done,  w_done_nxt;
    logic [c_WORD_W-1:0]             w_word;
    logic [c_DATA_BITS-1:0]          w_byte;
    logic                            w_valid;
    logic                            w_ready;
    logic                            w_last;
    logic                            w_tx;

    assign w_word  = bus.mem_data_i;
    assign w_byte  = c_DATA_BITS'(w_word);
    assign w_valid = (r_state == SEQ_LOAD);

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            // A request arriving alongside the done pulse belongs to the old dump.
            SEQ_IDLE: if (bus.dump_start_i && !r_done) begin
                w_addr_nxt  = '0;
                w_busy_nxt  = 1'b1;
                w_state_nxt = SEQ_LOAD;
            end
            SEQ_LOAD: if (w_ready) w_state_nxt = SEQ_SEND;
            SEQ_SEND: if (w_last) begin
                if (r_addr == c_ADDR_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_addr_nxt  = '0;
                    w_state_nxt = SEQ_IDLE;
                end else begin
                    w_addr_nxt  = r_addr + 1'b1;
                    w_state_nxt = SEQ_LOAD;
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= SEQ_IDLE;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    program_dump_tx_uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_serializer (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_byte  (w_byte),
        .i_valid (w_valid),
        .o_ready (w_ready),
        .o_last  (w_last),
        .o_tx    (w_tx)
    );

    assign bus.mem_addr_o = r_addr;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.tx_o       = w_tx;

endmodule
`default_nettype wire

// File: tb/tb_program_dump_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_dump_tx
// Description : Directed bench for program_dump_tx with a UART byte decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_dump_tx;
    localparam int c_CPB   = 4;
    localparam int c_REGS  = 16;
    localparam int c_DUMP  = 656;

    logic       clk;
    logic       reset;
    logic [6:0] mem [c_REGS];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] mon_q [$];

    program_dump_tx_if #(.ADDR_W(4), .WORD_W(7)) bus ();

    assign bus.mem_data_i = mem[bus.mem_addr_o];

    program_dump_tx #(
        .CLKS_PER_BIT         (c_CPB),
        .OPERATION_CODE_WIDTH (3),
        .REGISTER_WIDTH       (4),
        .MEMORY_ADDRESS_WIDTH (4),
        .MEMORY_REGISTERS     (c_REGS)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART decoder: mon_cnt is the index of the previous sample of the frame.
    logic       mon_active = 1'b0;
    int         mon_cnt    = 0;
    logic [7:0] mon_byte   = '0;
    always @(negedge clk) begin
        if (!mon_active) begin
            if (bus.tx_o === 1'b0) begin
                mon_active <= 1'b1;
                mon_cnt    <= 1;
            end
        end else begin
            mon_cnt <= mon_cnt + 1;
            if (mon_cnt >= 5 && mon_cnt <= 33 && ((mon_cnt - 5) % 4) == 0)
                mon_byte[(mon_cnt - 5) / 4] <= bus.tx_o;
            if (mon_cnt == 37) begin
                mon_q.push_back(mon_byte);
                mon_active <= 1'b0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         bad;
        int         hits;
        int         done_at;
        int         base;
        logic [9:0] fb;

        reset            = 1'b1;
        bus.dump_start_i = 1'b0;
        for (int a = 0; a < c_REGS; a++) mem[a] = 7'(a * 5);
        mem[0] = 7'b101_0011;

        // Reset state and a quiet idle period
        repeat (3) tick;
        chk("rst_tx",   32'(bus.tx_o),       1);
        chk("rst_busy", 32'(bus.busy_o),     0);
        chk("rst_done", 32'(bus.done_o),     0);
        chk("rst_addr", 32'(bus.mem_addr_o), 0);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            tick;
            if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 ||
                bus.mem_addr_o !== 4'd0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // First dump: word 0 = 0x53 checked bit by bit; memory altered mid-frame
        fb = {1'b1, 8'h53, 1'b0};
        bus.dump_start_i = 1'b1;
        tick;
        bus.dump_start_i = 1'b0;
        chk("busy_rise", 32'(bus.busy_o),     1);
        chk("load_tx",   32'(bus.tx_o),       1);
        chk("load_addr", 32'(bus.mem_addr_o), 0);
        hits    = 0;
        done_at = -1;
        for (int c = 1; c <= c_DUMP; c++) begin
            tick;
            if (c == 3) mem[0] = 7'h00;
            if (c <= 40) chk($sformatf("frame0_c%0d", c), 32'(bus.tx_o), 32'(fb[(c - 1) / 4]));
            if (c == 41) chk("addr_after_frame0", 32'(bus.mem_addr_o), 1);
            if (c == 200) bus.dump_start_i = 1'b1;
            if (c == 201) bus.dump_start_i = 1'b0;
            if (c == 655) chk("busy_before_done", 32'(bus.busy_o), 1);
            if (bus.done_o === 1'b1) begin
                hits++;
                done_at = c;
            end
        end
        chk("done_cycle_b", done_at, c_DUMP);
        chk("busy_at_done", 32'(bus.busy_o),     0);
        chk("addr_at_done", 32'(bus.mem_addr_o), 0);
        bus.dump_start_i = 1'b1;
        tick;
        bus.dump_start_i = 1'b0;
        if (bus.done_o === 1'b1) hits++;
        chk("req_in_done_ignored", 32'(bus.busy_o), 0);
        repeat (3) tick;
        chk("done_once_b",  hits, 1);
        chk("still_idle",   32'(bus.busy_o), 0);
        chk("bytes_b",      mon_q.size(), 16);
        chk("byte0_frozen", 32'(mon_q[0]), 32'h53);
        chk("byte1_b",      32'(mon_q[1]), 32'h05);

        // Second dump five cycles after done: full byte sequence and done timing
        tick;
        base = mon_q.size();
        bus.dump_start_i = 1'b1;
        tick;
        bus.dump_start_i = 1'b0;
        chk("busy_c", 32'(bus.busy_o),     1);
        chk("addr_c", 32'(bus.mem_addr_o), 0);
        hits    = 0;
        done_at = -1;
        for (int c = 1; c <= c_DUMP + 4; c++) begin
            tick;
            if (bus.done_o === 1'b1) begin
                hits++;
                done_at = c;
            end
        end
        chk("done_cycle_c", done_at, c_DUMP);
        chk("done_once_c",  hits, 1);
        chk("bytes_c",      mon_q.size() - base, 16);
        for (int a = 0; a < c_REGS; a++)
            chk($sformatf("byte_c_%0d", a), 32'(mon_q[base + a]), (a * 5) % 128);
        chk("end_busy_c", 32'(bus.busy_o),     0);
        chk("end_addr_c", 32'(bus.mem_addr_o), 0);

        // Third dump aborted by reset during bit 4 of word 3 (0x0F -> bit 4 = 0)
        bus.dump_start_i = 1'b1;
        tick;
        bus.dump_start_i = 1'b0;
        for (int c = 1; c <= 145; c++) tick;
        chk("pre_reset_addr", 32'(bus.mem_addr_o), 3);
        chk("pre_reset_tx",   32'(bus.tx_o),       0);
        #2 reset = 1'b1;
        #1;
        chk("async_tx",   32'(bus.tx_o),       1);
        chk("async_busy", 32'(bus.busy_o),     0);
        chk("async_addr", 32'(bus.mem_addr_o), 0);
        tick;
        tick;
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            tick;
            if (bus.tx_o !== 1'b1 || bus.busy_o !== 1'b0) bad++;
        end
        chk("no_resume", bad, 0);
        bus.dump_start_i = 1'b1;
        tick;
        bus.dump_start_i = 1'b0;
        chk("restart_busy", 32'(bus.busy_o),     1);
        chk("restart_addr", 32'(bus.mem_addr_o), 0);
        for (int c = 1; c <= 41; c++) tick;
        chk("restart_addr1", 32'(bus.mem_addr_o), 1);
        chk("restart_byte0", 32'(mon_q[mon_q.size() - 1]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/program_dump_tx.md
Name: program_dump_tx

Overview:
Serial read-back path for the 4-bit CPU's program memory. It is the transmit-side counterpart of the rx_i program loader. On a dump request it walks all program-memory addresses from 0 upward. Each instruction word is sent as one 8N1 UART byte on a single output pin, so the host can verify a downloaded program. It sits next to the CPU, takes a combinational read port into program memory, and drives one uo_out pin at top level.

Parameters:
CLKS_PER_BIT, 1042, clock cycles per UART bit (10 MHz / 9600 baud); must be >= 2
OPERATION_CODE_WIDTH, 3, opcode field width of an instruction word
REGISTER_WIDTH, 4, operand field width of an instruction word
MEMORY_ADDRESS_WIDTH, 4, program-memory address width
MEMORY_REGISTERS, 16, number of words dumped; must be <= 2**MEMORY_ADDRESS_WIDTH

Ports:
clk_i  input  1  system clock; one clock domain
reset_i  input  1  asynchronous, active-high reset
dump_start_i  input  1  single-cycle request to start a full dump; already synchronised upstream
mem_addr_o  output  MEMORY_ADDRESS_WIDTH  program-memory read address (registered)
mem_data_i  input  OPERATION_CODE_WIDTH+REGISTER_WIDTH  instruction at mem_addr_o; combinational, valid in the same cycle
tx_o  output  1  UART serial output; idle high; registered
busy_o  output  1  high from dump acceptance until after the last stop bit
done_o  output  1  one-cycle pulse after the last word's stop bit

Behaviour:
- Reset values, async on reset_i high: tx_o=1, busy_o=0, done_o=0, mem_addr_o=0, state IDLE, counters 0.
- Reset mid-frame aborts immediately. tx_o returns high; no partial frame resumes after release.
- States and transitions:
  - IDLE: tx_o=1. If dump_start_i=1, set mem_addr_o<=0 and busy_o<=1, then go to LOAD.
  - LOAD: one cycle. shift_reg <= {zero pad, mem_data_i}, i.e. opcode in the upper field bits and operand in the lower bits, zero-extended to 8 bits. Clear the baud counter, then go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx_o=shift_reg[bit_idx], sent LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles.
    - If mem_addr_o == MEMORY_REGISTERS-1: done_o=1 for one cycle, busy_o<=0, mem_addr_o<=0, go to IDLE.
    - Otherwise: mem_addr_o<=mem_addr_o+1, go to LOAD.
- Timing:
  - Frame = 1 LOAD cycle + 10*CLKS_PER_BIT cycles.
  - Full dump = MEMORY_REGISTERS*(1+10*CLKS_PER_BIT) cycles.
  - tx_o falls in the cycle after LOAD.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. Its width is $clog2(CLKS_PER_BIT).
- dump_start_i is ignored while busy_o=1, including a request in the same cycle as done_o. No queuing.
- The address does not wrap past MEMORY_REGISTERS-1 within a dump.
- mem_data_i is sampled only in LOAD. Memory changes during a frame do not affect the byte in flight.

Decomposition:
- Shared package (cpu_pkg): DATA_BITS=8, UART idle/start/stop levels, and the dump state enum (IDLE, LOAD, START, DATA, STOP).
- Natural sub-module: uart_tx_serializer.
  - Interface: byte in, valid/ready handshake, CLKS_PER_BIT parameter.
  - Handles START/DATA/STOP and the baud counter.
- program_dump_tx keeps the address sequencer, LOAD/IDLE control, busy_o and done_o.

Test Plan:
- Test bench uses CLKS_PER_BIT=4 and MEMORY_REGISTERS=16; frame = 41 cycles, full dump = 656 cycles.
- Reset release: tx_o=1, busy_o=0, mem_addr_o=0; no activity for 100 cycles with dump_start_i=0.
- Memory word 0 = 7'b101_0011 (byte 0x53), pulse dump_start_i:
  - busy_o rises next cycle; tx_o low from cycle 2 for 4 cycles.
  - Data bits 1,1,0,0,1,0,1,0, each held 4 cycles.
  - Stop bit high for 4 cycles; mem_addr_o=1 afterwards.
- Memory filled with addr*5 mod 128: UART monitor decodes 16 bytes 0x00,0x05,...,0x4B in order. done_o pulses exactly once at cycle 656; then busy_o=0 and mem_addr_o=0.
- dump_start_i pulsed again mid-dump and in the done_o cycle: byte count stays 16 and no second dump starts. A pulse 5 cycles after done_o starts a new dump from address 0.
- reset_i asserted during DATA of word 3: tx_o=1 and busy_o=0 in the same cycle, asynchronously. A new dump after release restarts at address 0.
